// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: per-stage hold vector plus sequencing for multi-cycle DIV and MADD ops in EX.
// Optional divide watchdog enabled by defining PIPE_CTRL_DIV_WATCHDOG_EN.
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       stallreq_from_if,
    input  logic       stallreq_from_id,
    input  logic       ex_div_req,
    input  logic       ex_madd_req,
    input  logic       div_ready_i,
    input  logic       stallreq_from_mem,
    output logic [5:0] stall,
    output logic       div_start_o,
    output logic       div_done_o,
    output logic       madd_second_o,
    output logic       div_timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_DONE,
        MADD_2
    } state_t;

    state_t state;
    state_t state_n;
    logic   div_start_n;
    logic   ex_busy;
    logic   wd_expired;

`ifdef PIPE_CTRL_DIV_WATCHDOG_EN
    logic [5:0] wd_cnt;

    // Expiry is taken on the edge that brings the count of DIV_RUN cycles to 63.
    assign wd_expired = (wd_cnt == 6'd62);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt        <= 6'd0;
            div_timeout_o <= 1'b0;
        end else begin
            if (state == IDLE && state_n == DIV_RUN) begin
                wd_cnt <= 6'd0;
            end else if (state == DIV_RUN) begin
                wd_cnt <= wd_cnt + 6'd1;
            end
            div_timeout_o <= (state == DIV_RUN) && !div_ready_i && wd_expired;
        end
    end
`else
    assign wd_expired    = 1'b0;
    assign div_timeout_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_start_o <= 1'b0;
        end else begin
            state       <= state_n;
            div_start_o <= div_start_n;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        div_start_n = 1'b0;
        case (state)
            IDLE: begin
                if (ex_div_req && !stallreq_from_mem) begin
                    state_n     = DIV_RUN;
                    div_start_n = 1'b1;
                end else if (ex_madd_req && !ex_div_req && !stallreq_from_mem) begin
                    state_n = MADD_2;
                end
            end
            DIV_RUN: begin
                if (div_ready_i) begin
                    state_n = DIV_DONE;
                end else if (wd_expired) begin
                    state_n = IDLE;
                end
            end
            DIV_DONE, MADD_2: begin
                if (!stallreq_from_mem) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ex_busy = ((state == IDLE) && (ex_div_req || ex_madd_req)) || (state == DIV_RUN);

    // Highest stalled stage wins; reset masks everything so the pipeline sees no hold.
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            stall = 6'b000000;
        end else if (stallreq_from_mem) begin
            stall = 6'b011111;
        end else if (ex_busy) begin
            stall = 6'b001111;
        end else if (stallreq_from_id) begin
            stall = 6'b000111;
        end else if (stallreq_from_if) begin
            stall = 6'b000011;
        end
    end

    assign div_done_o    = (state == DIV_DONE);
    assign madd_second_o = (state == MADD_2);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the stall rules.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_DIV_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stallreq_from_if = 1'b0;
    logic       stallreq_from_id = 1'b0;
    logic       ex_div_req = 1'b0;
    logic       ex_madd_req = 1'b0;
    logic       div_ready_i = 1'b0;
    logic       stallreq_from_mem = 1'b0;
    logic [5:0] stall;
    logic       div_start_o;
    logic       div_done_o;
    logic       madd_second_o;
    logic       div_timeout_o;

    int checks = 0;
    int failures = 0;

    // Model: what the controller is doing, in operation terms.
    bit m_in_div;       // divide launched, result not yet back
    int m_div_elapsed;  // DIV_RUN cycles completed so far
    bit m_done;         // result-capture cycle
    bit m_madd;         // accumulate-half cycle
    bit m_start;        // launch pulse this cycle
    bit m_timeout;      // watchdog abort pulse this cycle

    pipe_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_id  (stallreq_from_id),
        .ex_div_req        (ex_div_req),
        .ex_madd_req       (ex_madd_req),
        .div_ready_i       (div_ready_i),
        .stallreq_from_mem (stallreq_from_mem),
        .stall             (stall),
        .div_start_o       (div_start_o),
        .div_done_o        (div_done_o),
        .madd_second_o     (madd_second_o),
        .div_timeout_o     (div_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_in_div      = 1'b0;
        m_div_elapsed = 0;
        m_done        = 1'b0;
        m_madd        = 1'b0;
        m_start       = 1'b0;
        m_timeout     = 1'b0;
    endtask

    function automatic logic [5:0] exp_stall();
        bit idle;
        idle = !m_in_div && !m_done && !m_madd;
        if (rst) return 6'b000000;
        if (stallreq_from_mem) return 6'b011111;
        if (m_in_div || (idle && (ex_div_req || ex_madd_req))) return 6'b001111;
        if (stallreq_from_id) return 6'b000111;
        if (stallreq_from_if) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic model_update();
        m_start   = 1'b0;
        m_timeout = 1'b0;
        if (rst) begin
            model_clear();
        end else if (m_in_div) begin
            if (div_ready_i) begin
                m_in_div = 1'b0;
                m_done   = 1'b1;
            end else if (WD_EN && (m_div_elapsed + 1 >= 63)) begin
                m_in_div  = 1'b0;
                m_timeout = 1'b1;
            end else begin
                m_div_elapsed++;
            end
        end else if (m_done || m_madd) begin
            if (!stallreq_from_mem) begin
                m_done = 1'b0;
                m_madd = 1'b0;
            end
        end else if (!stallreq_from_mem) begin
            if (ex_div_req) begin
                m_in_div      = 1'b1;
                m_div_elapsed = 0;
                m_start       = 1'b1;
            end else if (ex_madd_req) begin
                m_madd = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit f_if, input bit f_id, input bit div, input bit madd,
                         input bit rdy, input bit mem);
        stallreq_from_if  = f_if;
        stallreq_from_id  = f_id;
        ex_div_req        = div;
        ex_madd_req       = madd;
        div_ready_i       = rdy;
        stallreq_from_mem = mem;
    endtask

    task automatic sample_now(input string tag);
        check({tag, ".stall"},   stall,         exp_stall());
        check({tag, ".start"},   div_start_o,   6'(m_start));
        check({tag, ".done"},    div_done_o,    6'(m_done));
        check({tag, ".madd2"},   madd_second_o, 6'(m_madd));
        check({tag, ".timeout"}, div_timeout_o, 6'(m_timeout));
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        sample_now(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input string tag, input bit f_if, input bit f_id, input bit div,
                        input bit madd, input bit rdy, input bit mem);
        drive(f_if, f_id, div, madd, rdy, mem);
        sample(tag);
        advance();
    endtask

    // Asynchronous reset raised mid-cycle; outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_clear();
        sample_now(tag);
        check({tag, ".stall0"}, stall, 6'b000000);
        check({tag, ".done0"},  div_done_o, 6'b0);
        advance();
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #1 rst = 1'b1;
        #1;
        sample_now("reset");
        check("reset.stall0", stall, 6'b000000);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-stage requests.
        drive(0, 1, 0, 0, 0, 0); sample("id_only"); check("id_only.d", stall, 6'b000111); advance();
        drive(0, 0, 0, 0, 0, 0); sample("id_rel");  check("id_rel.d",  stall, 6'b000000); advance();
        drive(1, 0, 0, 0, 0, 0); sample("if_only"); check("if_only.d", stall, 6'b000011); advance();
        drive(1, 1, 0, 0, 0, 1); sample("mem_all"); check("mem_all.d", stall, 6'b011111); advance();

        // Divide: request at cycle 0, result at cycle 33, capture at 34.
        drive(0, 0, 1, 0, 0, 0); sample("div_c0"); check("div_c0.d", stall, 6'b001111); advance();
        for (int c = 1; c <= 33; c++) begin
            drive(0, 0, 1, 0, (c == 33), 0);
            sample("div_run");
            check("div_run.stall_d", stall, 6'b001111);
            check("div_run.start_d", div_start_o, 6'(c == 1));
            advance();
        end
        drive(0, 0, 0, 0, 0, 0); sample("div_c34");
        check("div_c34.done_d", div_done_o, 6'b1);
        check("div_c34.stall_d", stall, 6'b000000);
        advance();
        step("div_c35", 0, 0, 0, 0, 0, 0);

        // MADD second half.
        drive(0, 0, 0, 1, 0, 0); sample("madd1"); check("madd1.d", stall, 6'b001111); advance();
        drive(0, 0, 0, 0, 0, 0); sample("madd2"); check("madd2.d", madd_second_o, 6'b1); advance();
        drive(0, 0, 0, 0, 0, 0); sample("madd3"); check("madd3.d", madd_second_o, 6'b0); advance();

        // Mem stall during DIV_RUN cycles 5-8; result at 12, capture at 13.
        step("dm_c0", 0, 0, 1, 0, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            drive(0, 0, 0, 0, (c == 12), (c >= 5 && c <= 8));
            sample("dm_run");
            if (c >= 5 && c <= 8) check("dm_run.mem_d", stall, 6'b011111);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0); sample("dm_c13"); check("dm_c13.done_d", div_done_o, 6'b1); advance();
        step("dm_c14", 0, 0, 0, 0, 0, 0);

        // Divide blocked by mem in IDLE, then both DIV and MADD requested together.
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 1, 1, 0, 1); sample("div_mem"); check("div_mem.start_d", div_start_o, 6'b0); advance();
        end
        step("div_madd", 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0); sample("dmx_1");
        check("dmx_1.start_d", div_start_o, 6'b1); check("dmx_1.madd_d", madd_second_o, 6'b0); advance();
        step("dmx_2", 0, 0, 0, 0, 0, 0);
        step("dmx_3", 0, 0, 0, 0, 0, 0);

        // Reset at DIV_RUN cycle 10 abandons the divide; a new request relaunches.
        step("rd_c0", 0, 0, 1, 0, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            drive(0, 0, 1, 0, 0, 0);
            sample("rd_run");
            if (c < 10) advance();
        end
        pulse_reset("rd_rst");
        for (int c = 0; c < 3; c++) step("rd_idle", 0, 0, 0, 0, 1, 0);
        step("rd_re0", 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0); sample("rd_re1"); check("rd_re1.start_d", div_start_o, 6'b1); advance();
        step("rd_re2", 0, 0, 0, 0, 0, 0);
        step("rd_re3", 0, 0, 0, 0, 0, 0);

        // Long divide with no result.
        step("wd_c0", 0, 0, 1, 0, 0, 0);
`ifdef PIPE_CTRL_DIV_WATCHDOG_EN
        for (int c = 1; c <= 63; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            sample("wd_run");
            check("wd_run.stall_d", stall, 6'b001111);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0); sample("wd_c64");
        check("wd_c64.to_d", div_timeout_o, 6'b1);
        check("wd_c64.stall_d", stall, 6'b000000);
        advance();
        drive(0, 0, 0, 0, 0, 0); sample("wd_c65"); check("wd_c65.to_d", div_timeout_o, 6'b0); advance();
`else
        for (int c = 1; c <= 70; c++) begin
            drive(0, 0, 0, 0, (c == 70), 0);
            sample("nowd_run");
            check("nowd_run.stall_d", stall, 6'b001111);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0); sample("nowd_c71"); check("nowd_c71.done_d", div_done_o, 6'b1); advance();
`endif

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            sample("rand");
            if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
            else advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL provide: stallreq_from_if  input  1  instruction fetch not ready.
REQ-004 SHALL provide: stallreq_from_id  input  1  load-use hazard detected in decode.
REQ-005 SHALL provide: ex_div_req  input  1  EX holds a DIV/DIVU needing the divider.
REQ-006 SHALL provide: ex_madd_req  input  1  EX holds MADD/MADDU/MSUB/MSUBU (two-cycle op).
REQ-007 SHALL provide: div_ready_i  input  1  divider result valid this cycle.
REQ-008 SHALL provide: stallreq_from_mem  input  1  memory stage not ready.
REQ-009 SHALL provide: stall  output  6  per-stage hold; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop.
REQ-010 SHALL provide: div_start_o  output  1  one-cycle divider launch pulse, registered.
REQ-011 SHALL provide: div_done_o  output  1  high in DIV_DONE; EX captures quotient/remainder.
REQ-012 SHALL provide: madd_second_o  output  1  high in MADD_2; EX performs accumulate half.
REQ-013 SHALL provide: div_timeout_o  output  1  one-cycle watchdog abort pulse, registered.

Function
REQ-014 SHALL implement FSM states IDLE, DIV_RUN, DIV_DONE, MADD_2; encoding free.
REQ-015 SHALL compute stall combinationally from state and request inputs, zero latency, priority highest stage first: mem -> 011111; EX busy -> 001111; id -> 000111; if -> 000011; none -> 000000.
REQ-016 SHALL treat EX busy as (IDLE and ex_div_req) or (IDLE and ex_madd_req) or DIV_RUN.
REQ-017 SHALL, in IDLE with ex_div_req=1 and stallreq_from_mem=0, enter DIV_RUN next edge and assert div_start_o for exactly that first DIV_RUN cycle.
REQ-018 SHALL, in IDLE with ex_div_req=1 and stallreq_from_mem=1, remain IDLE and not launch the divider.
REQ-019 SHALL, in IDLE with ex_madd_req=1, ex_div_req=0, stallreq_from_mem=0, enter MADD_2 for one cycle, then IDLE.
REQ-020 SHALL, when ex_div_req and ex_madd_req are both 1, give the divide precedence and ignore madd.
REQ-021 SHALL, in DIV_RUN, hold until div_ready_i=1, then enter DIV_DONE; div_ready_i sampled in any other state is ignored.
REQ-022 SHALL keep EX released in DIV_DONE and MADD_2 (only mem/id/if requests stall), returning to IDLE next edge unless stallreq_from_mem=1, in which case the state holds.
REQ-023 SHALL let stallreq_from_mem override stall encoding in any state without altering DIV_RUN progress.
REQ-024 SHALL never assert div_start_o again until the FSM has returned to IDLE.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, stall=000000, div_start_o=0, div_done_o=0, madd_second_o=0, div_timeout_o=0, watchdog counter 0, independent of clk.
REQ-026 SHALL, on rst asserted mid-DIV_RUN, abandon the divide with no div_done_o and resume from IDLE after release.

Configuration
REQ-027 SHALL, with macro PIPE_CTRL_DIV_WATCHDOG_EN defined, include a 6-bit counter cleared on entry to DIV_RUN, incremented each DIV_RUN cycle; at count 63 without div_ready_i the FSM returns to IDLE and div_timeout_o pulses one cycle.
REQ-028 SHALL, without PIPE_CTRL_DIV_WATCHDOG_EN, omit the counter, tie div_timeout_o to 0, and wait in DIV_RUN indefinitely.

Verification
REQ-029 SHALL cover: stallreq_from_id=1 only -> stall=000111 same cycle; release -> 000000.
REQ-030 SHALL cover: ex_div_req=1 at cycle 0, div_ready_i=1 at cycle 33 -> div_start_o at cycle 1 only, stall=001111 cycles 0-33, div_done_o at cycle 34, stall=000000 at 34.
REQ-031 SHALL cover: ex_madd_req=1 one cycle -> stall=001111 that cycle, madd_second_o=1 next cycle, then IDLE.
REQ-032 SHALL cover: stallreq_from_mem=1 during DIV_RUN cycles 5-8 -> stall=011111 there, div_done_o still follows div_ready_i by one cycle.
REQ-033 SHALL cover: rst pulse at DIV_RUN cycle 10 -> all outputs 0 immediately, no div_done_o, div_start_o reissued after new ex_div_req.
REQ-034 SHALL cover (macro defined): div_ready_i held 0 -> div_timeout_o pulses after 63 DIV_RUN cycles, stall returns to 000000.
